// File: rtl/i2s_tx.sv
// I2S transmitter: serialises each sample MSB-first into both the left and
// right slots, with a one-entry holding buffer and an underrun pulse.
module i2s_tx #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IN,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             SCK,
    output logic             WS,
    output logic             SD,
    output logic             underrun
);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(2 * WIDTH);

    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
    localparam logic [BW-1:0] B_LAST  = BW'(2 * WIDTH - 1);
    localparam logic [BW-1:0] B_SLOT  = BW'(WIDTH);

    logic [PW-1:0]    ph;
    logic [BW-1:0]    b;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] hold;
    logic             full;

    logic             ph_wrap;
    logic             load;
    logic             accept;
    logic [PW-1:0]    ph_next;
    logic [BW-1:0]    b_next;
    logic [BW-1:0]    pos;
    logic [WIDTH-1:0] aligned;
    logic             stream_bit;

    assign in_ready = ~full;

    always_comb begin
        ph_wrap = (ph == PH_LAST);
        load    = ph_wrap && (b == B_LAST);
        accept  = in_valid && !full;
        ph_next = ph_wrap ? '0 : ph + 1'b1;
        b_next  = b;
        if (ph_wrap) begin
            b_next = (b == B_LAST) ? '0 : b + 1'b1;
        end
        // Position inside the current slot; both slots send the word MSB-first.
        pos        = (b < B_SLOT) ? b : b - B_SLOT;
        aligned    = word << pos;
        stream_bit = aligned[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph       <= '0;
            b        <= '0;
            word     <= '0;
            hold     <= '0;
            full     <= 1'b0;
            SCK      <= 1'b0;
            WS       <= 1'b0;
            SD       <= 1'b0;
            underrun <= 1'b0;
        end else begin
            ph       <= ph_next;
            b        <= b_next;
            SCK      <= (ph_next >= PH_HIGH);
            WS       <= (b_next >= B_SLOT);
            underrun <= load && !full;
            // Bit b goes out during period b+1: the one-bit I2S delay.
            if (ph_wrap) begin
                SD <= stream_bit;
            end
            if (load) begin
                word <= full ? hold : '0;
                full <= 1'b0;
            end
            // An accept can only happen with the buffer empty, so it
            // refills the buffer even on a load edge.
            if (accept) begin
                hold <= IN;
                full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: CLK_DIV=2 and CLK_DIV=1 instances checked every cycle
// against a frame-level reference model, plus directed tables.
module tb_i2s_tx;
    localparam int W  = 8;
    localparam int HN = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] IN       = '0;
    logic [1:0]   in_ready, sck, ws, sd, und;

    i2s_tx #(.WIDTH(W), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .IN(IN), .in_valid(in_valid),
        .in_ready(in_ready[0]), .SCK(sck[0]), .WS(ws[0]),
        .SD(sd[0]), .underrun(und[0])
    );

    i2s_tx #(.WIDTH(W), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .IN(IN), .in_valid(in_valid),
        .in_ready(in_ready[1]), .SCK(sck[1]), .WS(ws[1]),
        .SD(sd[1]), .underrun(und[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic int period(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic int frame_len(int k);
        return 2 * W * period(k);
    endfunction

    // Reference model: cycle count since reset, word of the current and
    // previous frame, and the single pending sample.
    int           m_t[2];
    int           m_acc[2] = '{0, 0};
    logic [W-1:0] m_cur[2], m_prev[2], m_hold[2];
    bit           m_full[2], m_und[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k]    <= 0;
                m_cur[k]  <= '0;
                m_prev[k] <= '0;
                m_full[k] <= 1'b0;
                m_und[k]  <= 1'b0;
            end else begin
                m_t[k]   <= m_t[k] + 1;
                m_und[k] <= 1'b0;
                if (m_t[k] % frame_len(k) == frame_len(k) - 1) begin
                    m_prev[k] <= m_cur[k];
                    m_cur[k]  <= m_full[k] ? m_hold[k] : '0;
                    m_und[k]  <= !m_full[k];
                    m_full[k] <= 1'b0;
                end
                if (in_valid && !m_full[k]) begin
                    m_hold[k] <= IN;
                    m_full[k] <= 1'b1;
                    m_acc[k]  <= m_acc[k] + 1;
                end
            end
        end
    end

    function automatic logic exp_sck(int k);
        return (m_t[k] % period(k)) >= period(k) / 2;
    endfunction

    function automatic logic exp_ws(int k);
        return ((m_t[k] / period(k)) % (2 * W)) >= W;
    endfunction

    function automatic logic exp_sd(int k);
        int bi = (m_t[k] / period(k)) % (2 * W);
        logic [W-1:0] tmp;
        if (bi == 0) return m_prev[k][0];
        tmp = m_cur[k] >> (W - 1 - ((bi - 1) % W));
        return tmp[0];
    endfunction

    task automatic check(string name, int k, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t",
                     name, k, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(int k, logic s, logic w, logic d,
                           logic r, logic u);
        check("sck", k, int'(s), int'(exp_sck(k)));
        check("ws", k, int'(w), int'(exp_ws(k)));
        check("sd", k, int'(d), int'(exp_sd(k)));
        check("in_ready", k, int'(r), int'(!m_full[k]));
        check("underrun", k, int'(u), int'(m_und[k]));
    endtask

    logic h_sck [2][HN];
    logic h_ws  [2][HN];
    logic h_sd  [2][HN];
    logic h_rdy [2][HN];
    logic h_und [2][HN];

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, sck[0], ws[0], sd[0], in_ready[0], und[0]);
            cmp_dut(1, sck[1], ws[1], sd[1], in_ready[1], und[1]);
            if (m_t[0] < HN) begin
                h_sck[0][m_t[0]] <= sck[0];
                h_ws[0][m_t[0]]  <= ws[0];
                h_sd[0][m_t[0]]  <= sd[0];
                h_rdy[0][m_t[0]] <= in_ready[0];
                h_und[0][m_t[0]] <= und[0];
                h_sck[1][m_t[0]] <= sck[1];
                h_ws[1][m_t[0]]  <= ws[1];
                h_sd[1][m_t[0]]  <= sd[1];
                h_rdy[1][m_t[0]] <= in_ready[1];
                h_und[1][m_t[0]] <= und[1];
            end
        end
    end

    // Word carried by frame f, read MSB-first from bit periods 1..W.
    function automatic logic [W-1:0] word_of(int k, int f);
        logic [W-1:0] w = '0;
        for (int j = 0; j < W; j++) begin
            int n = f * 2 * W + j + 1;
            w = {w[W-2:0], h_sd[k][n * period(k) + period(k) - 1]};
        end
        return w;
    endfunction

    task automatic do_reset(int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int   n;
        logic sd;
    } sd_vec_t;

    sd_vec_t      a5_tab[17];
    logic [16:0]  a5_pat;
    logic [W-1:0] seq[4];
    int           base;
    int           idx;

    initial begin
        a5_pat = 17'b0_10100101_1010010_1;
        for (int i = 0; i < 17; i++) begin
            a5_tab[i] = '{16 + i, a5_pat[16 - i]};
        end
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Idle after reset: timing of SCK/WS and periodic underrun.
        @(negedge clk);
        do_reset(3);
        chk_en = 1'b1;
        check("rst_rdy", 0, int'(in_ready[0]), 1);
        check("rst_sck", 0, int'(sck[0]), 0);
        check("rst_und", 0, int'(und[0]), 0);
        repeat (140) @(negedge clk);
        check("sck_c1", 0, int'(h_sck[0][1]), 0);
        check("sck_c2", 0, int'(h_sck[0][2]), 1);
        check("sck_c1", 1, int'(h_sck[1][1]), 1);
        check("ws_c31", 0, int'(h_ws[0][31]), 0);
        check("ws_c32", 0, int'(h_ws[0][32]), 1);
        check("und_c63", 0, int'(h_und[0][63]), 0);
        check("und_c64", 0, int'(h_und[0][64]), 1);
        check("und_c65", 0, int'(h_und[0][65]), 0);
        check("und_c128", 0, int'(h_und[0][128]), 1);
        check("und_c32", 1, int'(h_und[1][32]), 1);

        // 8'hA5 accepted in frame 0, checked bit by bit in frame 1.
        do_reset(2);
        in_valid = 1'b1;
        IN       = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (140) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < period(k); p++) begin
                    check("a5_sd", k,
                          int'(h_sd[k][a5_tab[i].n * period(k) + p]),
                          int'(a5_tab[i].sd));
                end
            end
        end

        // Back-to-back samples with in_valid held high.
        do_reset(2);
        base     = m_acc[0];
        in_valid = 1'b1;
        IN       = seq[0];
        for (int c = 0; c < 330; c++) begin
            @(negedge clk);
            idx = m_acc[0] - base;
            if (idx >= 4) in_valid = 1'b0;
            else IN = seq[idx];
        end
        for (int f = 1; f <= 4; f++) begin
            check("seq_word", 0, int'(word_of(0, f)), int'(seq[f - 1]));
        end
        check("seq_rdy_c1", 0, int'(h_rdy[0][1]), 0);
        check("seq_rdy_c63", 0, int'(h_rdy[0][63]), 0);
        check("seq_rdy_c64", 0, int'(h_rdy[0][64]), 1);
        check("seq_rdy_c65", 0, int'(h_rdy[0][65]), 0);
        check("seq_rdy_c128", 0, int'(h_rdy[0][128]), 1);

        // Sample arriving exactly on a load edge with the buffer empty.
        do_reset(2);
        repeat (63) @(negedge clk);
        in_valid = 1'b1;
        IN       = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (200) @(negedge clk);
        check("edge_und", 0, int'(h_und[0][64]), 1);
        check("edge_rdy", 0, int'(h_rdy[0][64]), 0);
        check("edge_f1", 0, int'(word_of(0, 1)), 0);
        check("edge_f2", 0, int'(word_of(0, 2)), 8'h5A);

        // Reset mid-frame with a sample waiting in the buffer.
        do_reset(2);
        in_valid = 1'b1;
        IN       = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (63) @(negedge clk);
        in_valid = 1'b1;
        IN       = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_full", 0, int'(in_ready[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_sck", 0, int'(sck[0]), 0);
        check("mid_ws", 0, int'(ws[0]), 0);
        check("mid_sd", 0, int'(sd[0]), 0);
        check("mid_rdy", 0, int'(in_ready[0]), 1);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_f0", 0, int'(word_of(0, 0)), 0);
        check("mid_f1", 0, int'(word_of(0, 1)), 0);
        check("mid_f2", 0, int'(word_of(0, 2)), 0);
        check("mid_und63", 0, int'(h_und[0][63]), 0);
        check("mid_und64", 0, int'(h_und[0][64]), 1);

        // Random traffic: alternating busy and sparse phases, rare resets.
        do_reset(2);
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ((c / 1000) % 2 == 0) in_valid = ($urandom_range(0, 2) == 0);
            else in_valid = ($urandom_range(0, 99) == 0);
            IN = W'($urandom);
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
